gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_ctrl: RTL and testbench

//  Sequencer for a bank of SEGMENTS switchable fillcap (decap) segments.

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_ctrl.sv | 66 ++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_ctrl.sv
// gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_ctrl: staged on/off sequencer for a bank of fillcap segments
module gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_ctrl #(
  parameter int SEGMENTS    = 8,
  parameter int STEP_CYCLES = 4
) (
`ifdef USE_POWER_PINS
  inout  wire                 VDD,
  inout  wire                 VSS,
`endif
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                KILL,
  output logic [SEGMENTS-1:0] SEG_EN,
  output logic                READY,
  output logic                BUSY
);
  localparam int DW_W  = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  localparam int CNT_W = $clog2(SEGMENTS + 1);
  localparam logic [1:0] S_OFF = 2'd0, S_UP = 2'd1, S_ON = 2'd2, S_DN = 2'd3;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DW_W-1:0]  r_dw;
  logic             w_last, w_full;
  assign w_last = r_dw == DW_W'(STEP_CYCLES - 1);
  assign w_full = r_cnt == CNT_W'(SEGMENTS);
  // KILL shares the reset path so RST+KILL yields the identical cleared state
  always_ff @(posedge CLK)
    if (RST || KILL) begin
      r_state <= S_OFF;
      r_cnt   <= '0;
      r_dw    <= '0;
    end else
      case (r_state)
        S_OFF: if (EN) begin
          r_state <= S_UP;
          r_cnt   <= CNT_W'(1);
          r_dw    <= '0;
        end
        S_UP: if (!EN) begin
          r_state <= S_DN;
          r_dw    <= '0;
        end else if (w_last) begin
          r_dw <= '0;
          if (w_full) r_state <= S_ON;
          else r_cnt <= r_cnt + 1'b1;
        end else r_dw <= r_dw + 1'b1;
        S_ON: if (!EN) begin
          r_state <= S_DN;
          r_dw    <= '0;
        end
        default: if (EN) begin
          r_state <= S_UP;
          r_dw    <= '0;
        end else if (w_last) begin
          r_dw  <= '0;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) r_state <= S_OFF;
        end else r_dw <= r_dw + 1'b1;
      endcase
  for (genvar i = 0; i < SEGMENTS; i++) begin : g_seg
    assign SEG_EN[i] = r_cnt > CNT_W'(i);
  end
  assign READY = r_state == S_ON;
  assign BUSY  = r_state == S_UP || r_state == S_DN;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_ctrl.sv
// tb_gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_ctrl: scoreboard bench, 8x4 bank plus a 1x1 bank
module tb_gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_ctrl;
  logic       clk = 1'b0, rst = 1'b0, en = 1'b0, en1 = 1'b0, kill = 1'b0;
  logic [7:0] seg0;
  logic       rdy0, bsy0;
  logic [0:0] seg1;
  logic       rdy1, bsy1;
  int         cyc = 0, checks = 0, errors = 0;
  typedef struct {int at; int dut; logic [9:0] exp; string tag;} sb_t;
  sb_t q[$];
  sb_t ent;
  gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_ctrl #(.SEGMENTS(8), .STEP_CYCLES(4)) u_dut0 (
    .CLK(clk), .RST(rst), .EN(en), .KILL(kill), .SEG_EN(seg0), .READY(rdy0), .BUSY(bsy0));
  gf180mcu_fd_sc_mcu9t5v0__fillcap_bank_ctrl #(.SEGMENTS(1), .STEP_CYCLES(1)) u_dut1 (
    .CLK(clk), .RST(rst), .EN(en1), .KILL(kill), .SEG_EN(seg1), .READY(rdy1), .BUSY(bsy1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask
  // outputs are compared after the edge whose number matches the entry
  always @(negedge clk)
    while (q.size() > 0 && q[0].at <= cyc) begin
      ent = q.pop_front();
      chk(ent.at < cyc ? {ent.tag, "_late"} : ent.tag,
          ent.dut != 0 ? {7'b0, seg1, rdy1, bsy1} : {seg0, rdy0, bsy0}, ent.exp);
    end
  function automatic logic [9:0] pk(input int n, input logic r, input logic b);
    logic [8:0] t;
    t = (9'd1 << n) - 9'd1;
    return {t[7:0], r, b};
  endfunction
  task automatic push(input int at, input int d, input logic [9:0] e, input string tag);
    sb_t s;
    s.at = at; s.dut = d; s.exp = e; s.tag = tag;
    q.push_back(s);
  endtask
  task automatic go(input int e);
    while (cyc < e - 1) @(negedge clk);
  endtask
  task automatic drain();
    int t = 0;
    while (q.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", 10'(q.size()), 10'd0);
      q.delete();
    end
  endtask
  task automatic rst_pulse();
    rst = 1'b1; en = 1'b0; en1 = 1'b0; kill = 1'b0;
    go(cyc + 2);
    rst = 1'b0;
  endtask
  initial begin
    int k;
    @(negedge clk);
    // T1: reset held with EN high
    k = cyc + 1;
    rst = 1'b1; en = 1'b1;
    push(k, 0, 10'd0, "t1_rst_a");
    push(k + 1, 0, 10'd0, "t1_rst_b");
    push(k + 2, 0, pk(1, 0, 1), "t1_release");
    go(k + 2);
    rst = 1'b0;
    drain();
    // T2: full ramp up
    rst_pulse();
    k = cyc + 1;
    for (int e = 0; e < 35; e++) push(k + e, 0, pk(e < 32 ? e / 4 + 1 : 8, e >= 32, e < 32), "t2_ramp_up");
    en = 1'b1;
    drain();
    // T3: full ramp down from ON
    k = cyc + 1;
    for (int e = 0; e < 34; e++) push(k + e, 0, pk(e < 32 ? 8 - e / 4 : 0, 1'b0, e < 32), "t3_ramp_dn");
    en = 1'b0;
    drain();
    // T4a: reverse mid-ramp at CNT=3
    rst_pulse();
    k = cyc + 1;
    push(k + 8, 0, pk(3, 0, 1), "t4_cnt3");
    push(k + 9, 0, pk(3, 0, 1), "t4_rev");
    push(k + 12, 0, pk(3, 0, 1), "t4_dwell");
    push(k + 13, 0, pk(2, 0, 1), "t4_dn2");
    push(k + 17, 0, pk(1, 0, 1), "t4_dn1");
    push(k + 21, 0, pk(0, 0, 0), "t4_off");
    push(k + 23, 0, pk(0, 0, 0), "t4_off_hold");
    en = 1'b1;
    go(k + 9);
    en = 1'b0;
    drain();
    // T4b: reverse down then back up
    rst_pulse();
    k = cyc + 1;
    push(k + 10, 0, pk(3, 0, 1), "t4b_up_again");
    push(k + 13, 0, pk(3, 0, 1), "t4b_dwell");
    push(k + 14, 0, pk(4, 0, 1), "t4b_cnt4");
    en = 1'b1;
    go(k + 9);
    en = 1'b0;
    go(k + 10);
    en = 1'b1;
    drain();
    // T5: KILL during ramp up, then restart
    rst_pulse();
    k = cyc + 1;
    push(k + 19, 0, pk(5, 0, 1), "t5_pre_kill");
    push(k + 20, 0, pk(0, 0, 0), "t5_kill");
    push(k + 21, 0, pk(1, 0, 1), "t5_restart");
    push(k + 25, 0, pk(2, 0, 1), "t5_step");
    push(k + 27, 0, pk(0, 0, 0), "t5_rst_kill");
    push(k + 28, 0, pk(1, 0, 1), "t5_after_both");
    en = 1'b1;
    go(k + 20);
    kill = 1'b1;
    go(k + 21);
    kill = 1'b0;
    go(k + 27);
    kill = 1'b1; rst = 1'b1;
    go(k + 28);
    kill = 1'b0; rst = 1'b0;
    drain();
    // T6: single segment, single-cycle step
    rst_pulse();
    k = cyc + 1;
    push(k, 1, {7'b0, 1'b1, 1'b0, 1'b1}, "t6_seg_on");
    push(k + 1, 1, {7'b0, 1'b1, 1'b1, 1'b0}, "t6_ready");
    push(k + 4, 1, {7'b0, 1'b1, 1'b1, 1'b0}, "t6_hold");
    push(k + 5, 1, {7'b0, 1'b1, 1'b0, 1'b1}, "t6_ready_fall");
    push(k + 6, 1, {7'b0, 1'b0, 1'b0, 1'b0}, "t6_off");
    en1 = 1'b1;
    go(k + 5);
    en1 = 1'b0;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end
endmodule
